// File: rtl/game_cmd_pkg.sv
// game_cmd_pkg: shared state type, command byte codes, source encodings and a saturating adder
package game_cmd_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [7:0] CMD_NONE    = 8'h00;
    localparam logic [7:0] CMD_RESTART = 8'h52;
    localparam logic [7:0] CMD_PAUSE   = 8'h50;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_KEY  = 2'd1;
    localparam logic [1:0] SRC_BT   = 2'd2;

    // Adds up to two dropped requests and holds at 255 instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes the raw active-low button and emits one pulse per accepted press
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   key_n       - raw button, active-low, asynchronous to clk
//   key_event   - one-cycle pulse on the debounced released-to-pressed edge
module key_debouncer #(
    parameter int KEY_DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_event
);

    localparam int CW = $clog2(KEY_DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settle;

    // The synchronized level must disagree with the accepted level for
    // KEY_DEBOUNCE_CYCLES consecutive cycles; settle marks the last of them.
    assign settle    = (sync2 != level) && (cnt == CW'(KEY_DEBOUNCE_CYCLES - 1));
    assign key_event = settle && sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_cmd_arbiter.sv
// game_cmd_arbiter: merges the debounced key and UART command bytes into jump/restart/pause control
// Ports:
//   clk, reset     - pixel clock and asynchronous active-high reset
//   key_n          - raw on-board jump button, active-low
//   rx_data        - UART byte, valid while rx_valid is high
//   rx_valid       - one-cycle byte strobe
//   game_alive     - 1 while the game core is running
//   jump_pulse     - one-cycle jump command
//   restart_pulse  - one-cycle restart command
//   paused         - high while in the PAUSED state
//   cmd_src        - source of the last granted jump (0 none, 1 key, 2 Bluetooth)
//   drop_count     - saturating count of dropped jump requests
module game_cmd_arbiter
    import game_cmd_pkg::*;
#(
    parameter int KEY_DEBOUNCE_CYCLES = 250000,
    parameter int JUMP_COOLDOWN       = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       game_alive,
    output logic       jump_pulse,
    output logic       restart_pulse,
    output logic       paused,
    output logic [1:0] cmd_src,
    output logic [7:0] drop_count
);

    localparam int CW = $clog2(JUMP_COOLDOWN + 1);

    logic          key_event;
    logic          req_key;
    logic          req_bt;
    logic          req_restart;
    logic          req_pause;
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cooldown;
    logic [CW-1:0] cool_n;
    logic          ptr_bt;
    logic          ptr_n;
    logic [1:0]    src_n;
    logic          jump_n;
    logic          restart_n;
    logic [1:0]    drops;
    logic          win_bt;

    key_debouncer #(
        .KEY_DEBOUNCE_CYCLES(KEY_DEBOUNCE_CYCLES)
    ) u_key (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .key_event(key_event)
    );

    assign paused = (state == ST_PAUSED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_key       <= 1'b0;
            req_bt        <= 1'b0;
            req_restart   <= 1'b0;
            req_pause     <= 1'b0;
            state         <= ST_RUN;
            cooldown      <= '0;
            ptr_bt        <= 1'b0;
            cmd_src       <= SRC_NONE;
            drop_count    <= '0;
            jump_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
        end else begin
            req_key       <= key_event;
            req_bt        <= rx_valid && !(rx_data inside {CMD_NONE, CMD_RESTART, CMD_PAUSE});
            req_restart   <= rx_valid && (rx_data == CMD_RESTART);
            req_pause     <= rx_valid && (rx_data == CMD_PAUSE);
            state         <= state_n;
            cooldown      <= cool_n;
            ptr_bt        <= ptr_n;
            cmd_src       <= src_n;
            drop_count    <= sat_add(drop_count, drops);
            jump_pulse    <= jump_n;
            restart_pulse <= restart_n;
        end
    end

    // Priority: DEAD handling, then restart, then loss of the game, then
    // pause/resume and jump arbitration. In PAUSED and DEAD a key event is a
    // resume/restart command rather than a jump request, so it is never dropped.
    always_comb begin
        state_n   = state;
        cool_n    = (cooldown != '0) ? cooldown - CW'(1) : '0;
        ptr_n     = ptr_bt;
        src_n     = cmd_src;
        jump_n    = 1'b0;
        restart_n = 1'b0;
        drops     = 2'd0;
        win_bt    = 1'b0;
        if (state == ST_DEAD) begin
            drops = {1'b0, req_bt};
            if (req_restart || req_key) begin
                restart_n = 1'b1;
                state_n   = ST_RUN;
            end
        end else if (req_restart) begin
            restart_n = 1'b1;
            state_n   = ST_RUN;
            cool_n    = '0;
            drops     = {1'b0, req_key && (state == ST_RUN)};
        end else if (!game_alive) begin
            state_n = ST_DEAD;
            cool_n  = '0;
            drops   = {1'b0, req_bt} + {1'b0, req_key && (state == ST_RUN)};
        end else if (state == ST_PAUSED) begin
            drops = {1'b0, req_bt};
            if (req_pause || req_key) state_n = ST_RUN;
        end else begin
            if (req_pause) state_n = ST_PAUSED;
            if (cooldown != '0) begin
                drops = {1'b0, req_bt} + {1'b0, req_key};
            end else if (req_key || req_bt) begin
                // On a tie the pointer names the source that did not win last.
                win_bt = req_bt && (!req_key || ptr_bt);
                drops  = {1'b0, req_key && req_bt};
                jump_n = 1'b1;
                src_n  = win_bt ? SRC_BT : SRC_KEY;
                ptr_n  = !win_bt;
                cool_n = CW'(JUMP_COOLDOWN);
            end
        end
    end

endmodule

// File: doc/game_cmd_arbiter.md
GAME_CMD_ARBITER -- requirements
Module: game_cmd_arbiter

Interface
REQ-001 Parameter KEY_DEBOUNCE_CYCLES, default 250000: consecutive stable cycles before a key level is accepted (10 ms at 25 MHz).
REQ-002 Parameter JUMP_COOLDOWN, default 5000000: cycles after a granted jump during which further jumps are dropped (200 ms).
REQ-003 clk  in  1  pixel clock; the only clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 key_n  in  1  raw on-board jump button, active-low, asynchronous to clk.
REQ-006 rx_data  in  8  UART byte, valid only while rx_valid=1.
REQ-007 rx_valid  in  1  one-cycle strobe, already synchronous to clk.
REQ-008 game_alive  in  1  level from game core; 1 = running.
REQ-009 jump_pulse  out  1  one-cycle jump command to game core.
REQ-010 restart_pulse  out  1  one-cycle restart command to game core.
REQ-011 paused  out  1  high while state = PAUSED.
REQ-012 cmd_src  out  2  source of the last granted jump: 0 none, 1 key, 2 Bluetooth.
REQ-013 drop_count  out  8  saturating count of dropped jump requests.

Function
REQ-014 key_n passes a 2-FF synchronizer, then a debouncer; one key event fires on the debounced released-to-pressed edge only.
REQ-015 Byte decode on rx_valid: 0x00 ignored; 0x52 'R' = restart; 0x50 'P' = pause toggle; any other byte = jump.
REQ-016 Decoded requests register in cycle N+1; grants and outputs appear in cycle N+2, where N is the rx_valid or key-event cycle.
REQ-017 States: RUN, PAUSED, DEAD; reset enters RUN.
REQ-018 RUN: 'P' goes to PAUSED; game_alive=0 goes to DEAD; jumps arbitrate per REQ-021.
REQ-019 PAUSED: 'P' or a key event returns to RUN with no jump; BT jumps are dropped; game_alive=0 goes to DEAD.
REQ-020 DEAD: 'R' or a key event pulses restart_pulse and goes to RUN; BT jumps and 'P' are dropped or ignored.
REQ-021 Arbitration: a jump is granted only in RUN with cooldown=0; a grant pulses jump_pulse, updates cmd_src and loads cooldown with JUMP_COOLDOWN.
REQ-022 Key and BT jump requests in the same cycle: a round-robin pointer picks the source not granted last; the loser is dropped; the pointer favours key after reset.
REQ-023 A jump request while cooldown>0, in PAUSED, or in DEAD increments drop_count; drop_count holds at 255 and never wraps.
REQ-024 'R' in RUN or PAUSED pulses restart_pulse, enters RUN, and clears cooldown.
REQ-025 Restart has precedence over jump and pause in the same cycle; the jump is counted as dropped.
REQ-026 jump_pulse and restart_pulse are never high in the same cycle.
REQ-027 Cooldown decrements by 1 per cycle down to 0; it is cleared on entry to DEAD.

Reset
REQ-028 Reset asserted forces, asynchronously:
- jump_pulse=0, restart_pulse=0, paused=0, cmd_src=0, drop_count=0;
- state=RUN, cooldown=0, round-robin pointer=key;
- synchronizer and debouncer cleared to released.
REQ-029 Reset mid-debounce or mid-cooldown discards all partial progress; no pulse is emitted on release.

Structure
REQ-030 Shared package game_cmd_pkg holds:
- state enum;
- byte constants CMD_RESTART=0x52 and CMD_PAUSE=0x50;
- cmd_src encodings.
REQ-031 Sub-module key_debouncer (synchronizer plus stable counter, parameter KEY_DEBOUNCE_CYCLES) provides the key event; all else is one module.

Verification (KEY_DEBOUNCE_CYCLES=4, JUMP_COOLDOWN=8)
REQ-032 rx_valid with 0x4A in cycle 10 -> jump_pulse=1 in cycle 12 only; cmd_src=2.
REQ-033 0x4A at cycle 10, then 0x20 at cycle 14 -> second request dropped, drop_count=1; 0x20 at cycle 22 -> granted.
REQ-034 Key event and BT jump in the same cycle after reset -> key granted (cmd_src=1), drop_count=1; repeat after cooldown -> BT granted.
REQ-035 Key bouncing with 3-cycle pulses -> no event; key held low for 6 cycles -> exactly one jump_pulse.
REQ-036 Sequences:
- game_alive=0 -> 0x4A dropped; 0x52 -> restart_pulse 2 cycles later, state RUN;
- 0x50 -> paused=1; key event -> paused=0 with no jump_pulse.
REQ-037 Reset asserted with cooldown=5 and drop_count=3 -> all outputs 0 immediately; 0x4A after release -> granted at N+2.
